// File: rtl/display_pkg.sv
// Shared segment codes and FSM encoding for the BCD display driver.
// Segment order in every 7-bit code is {a,b,c,d,e,f,g}, active-low.
package display_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_ERR   = 7'b0110000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_display_driver_if.sv
// Request/result bundle between the register readout control and the display driver.
//  value/update : operand and conversion request (master -> slave)
//  busy/done/overflow/hex_out/sign_seg : status and display segments (slave -> master)
interface bcd_display_driver_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIGITS = 7
);
  logic [DATA_W-1:0]   value;
  logic                update;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [7*DIGITS-1:0] hex_out;
  logic [6:0]          sign_seg;

  modport master (
    output value, update,
    input  busy, done, overflow, hex_out, sign_seg
  );

  modport slave (
    input  value, update,
    output busy, done, overflow, hex_out, sign_seg
  );
endinterface

// File: rtl/seg7_encode.sv
// One-digit BCD to active-low 7-segment encoder.
//  bcd   : digit value 0..9 (codes above 9 render as "E")
//  blank : force all segments off
//  err   : force "E", overrides blank
//  seg_c : combinational segment code {a..g}
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       err,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (err) begin
      seg_c = SEG_ERR;
    end else if (blank) begin
      seg_c = SEG_BLANK;
    end else if (bcd <= 4'd9) begin
      seg_c = SEG_DIGIT[bcd];
    end else begin
      seg_c = SEG_ERR;
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Signed binary to multi-digit 7-segment driver using a sequential double-dabble engine.
//  clk : system clock, rising edge
//  rst : asynchronous active-low reset
//  bus : slave side of bcd_display_driver_if (value/update in; busy/done/overflow/hex_out/sign_seg out)
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DIGITS   = 7,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic clk,
  input  logic rst,
  bcd_display_driver_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mag;
  logic [BCD_W-1:0]    bcd;
  logic                sign_r;
  logic                ovf_r;

  logic [BCD_W-1:0]    bcd_adj;
  logic [DIGITS-1:0]   lit;
  logic                any_nz;
  logic [7*DIGITS-1:0] seg_c;

  // Add-3 correction on every nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // A digit stays lit if it or any more significant digit is nonzero; digit 0 is always lit.
  always_comb begin
    any_nz = 1'b0;
    lit    = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      any_nz = any_nz | (bcd[4*i +: 4] != 4'd0);
      lit[i] = any_nz || (i == 0) || (BLANK_LZ == 0);
    end
  end

  // Per-digit segment encoders feeding the LOAD register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_encode u_seg (
      .bcd   (bcd[4*g +: 4]),
      .blank (!lit[g]),
      .err   (ovf_r),
      .seg_c (seg_c[7*g +: 7])
    );
  end

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mag          <= '0;
      bcd          <= '0;
      sign_r       <= 1'b0;
      ovf_r        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.hex_out  <= {DIGITS{SEG_DIGIT[0]}};
      bus.sign_seg <= SEG_BLANK;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.update) begin
            sign_r   <= bus.value[DATA_W-1];
            // Unsigned magnitude: the most negative value maps to 2**(DATA_W-1) exactly.
            mag      <= bus.value[DATA_W-1] ? (~bus.value + DATA_W'(1)) : bus.value;
            bcd      <= '0;
            ovf_r    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd   <= {bcd_adj[BCD_W-2:0], mag[DATA_W-1]};
          mag   <= {mag[DATA_W-2:0], 1'b0};
          // A bit leaving the top nibble means the magnitude needs one more digit.
          ovf_r <= ovf_r | bcd_adj[BCD_W-1];
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          bus.hex_out  <= seg_c;
          bus.sign_seg <= sign_r ? SEG_MINUS : SEG_BLANK;
          bus.overflow <= ovf_r;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
